// File: rtl/fanout_accumulator.sv
// ============================================================================
//  Module   : fanout_accumulator
//  Purpose  : Per-net fanout counter. At end-of-netlist it scans every net
//             and emits the (net, count) pairs that meet a threshold, then
//             clears itself. Optional macro FANOUT_ACC_SAT_EN selects
//             saturating counters; the default build wraps.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fanout_accumulator #(
    parameter int NET_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NET_W-1:0] in_net,
    input  logic             in_last,
    input  logic [CNT_W-1:0] thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NET_W-1:0] out_net,
    output logic [CNT_W-1:0] out_cnt,
    output logic             done,
    output logic             overflow
);

    localparam int               DEPTH    = 2**NET_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [NET_W-1:0] LAST_NET = NET_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q [DEPTH];
    logic [CNT_W-1:0]   cnt_d [DEPTH];
    logic [CNT_W-1:0]   thr_q,       thr_d;
    logic [NET_W-1:0]   p_q,         p_d;
    logic               scan_end_q,  scan_end_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [NET_W-1:0]   out_net_q,   out_net_d;
    logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
    logic               done_q,      done_d;
    logic               overflow_q,  overflow_d;

    logic               w_accept;
    logic               w_slot_free;

    assign w_accept    = in_valid & in_ready_q;
    assign w_slot_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        thr_d       = thr_q;
        p_d         = p_q;
        scan_end_d  = scan_end_q;
        out_valid_d = out_valid_q;
        out_net_d   = out_net_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;

        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (cnt_q[in_net] == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end
`ifdef FANOUT_ACC_SAT_EN
                    if (cnt_q[in_net] != CNT_MAX) begin
                        cnt_d[in_net] = cnt_q[in_net] + 1'b1;
                    end
`else
                    cnt_d[in_net] = cnt_q[in_net] + 1'b1;
`endif
                    if (in_last) begin
                        state_d    = ST_DRAIN;
                        thr_d      = thr;
                        p_d        = '0;
                        scan_end_d = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_slot_free) begin
                    // scan_end marks that the last net was evaluated; the
                    // extra cycle lets its result be consumed before done.
                    if (scan_end_q) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        scan_end_d  = 1'b0;
                        state_d     = ST_CLEAR;
                    end else begin
                        if ((cnt_q[p_q] != '0) && (cnt_q[p_q] >= thr_q)) begin
                            out_valid_d = 1'b1;
                            out_net_d   = p_q;
                            out_cnt_d   = cnt_q[p_q];
                        end else begin
                            out_valid_d = 1'b0;
                        end
                        p_d = p_q + 1'b1;
                        if (p_q == LAST_NET) begin
                            scan_end_d = 1'b1;
                        end
                    end
                end
            end

            ST_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    cnt_d[i] = '0;
                end
                state_d = ST_ACCUM;
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        in_ready_d = (state_d == ST_ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            thr_q       <= '0;
            p_q         <= '0;
            scan_end_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_net_q   <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
            p_q         <= p_d;
            scan_end_q  <= scan_end_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_net_q   <= out_net_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_net   = out_net_q;
    assign out_cnt   = out_cnt_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fanout_accumulator.sv
// ============================================================================
//  Module   : tb_fanout_accumulator
//  Purpose  : Scoreboard bench for fanout_accumulator with directed netlists.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fanout_accumulator;

    localparam int NET_W = 4;
    localparam int CNT_W = 4;
    localparam int DEPTH = 2**NET_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NET_W-1:0] in_net = '0;
    logic             in_last = 1'b0;
    logic [CNT_W-1:0] thr = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [NET_W-1:0] out_net;
    logic [CNT_W-1:0] out_cnt;
    logic             done;
    logic             overflow;

    fanout_accumulator #(.NET_W(NET_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_net    (in_net),
        .in_last   (in_last),
        .thr       (thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_net   (out_net),
        .out_cnt   (out_cnt),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int net;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int net, input int cnt);
        exp_t e;
        e.net = net;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops on each handshake.
    logic             prev_stall = 1'b0;
    logic [NET_W-1:0] prev_net   = '0;
    logic [CNT_W-1:0] prev_cnt   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin
                chk("done_no_overlap_valid", int'(out_valid), 0);
                chk("done_after_all_results", exp_q.size(), 0);
            end
            if (prev_stall) begin
                chk("stall_hold_valid", int'(out_valid), 1);
                chk("stall_hold_net", int'(out_net), int'(prev_net));
                chk("stall_hold_cnt", int'(out_cnt), int'(prev_cnt));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got net=%0d cnt=%0d expected none",
                             out_net, out_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_net", int'(out_net), e.net);
                    chk("out_cnt", int'(out_cnt), e.cnt);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_net   = out_net;
            prev_cnt   = out_cnt;
        end
    end

    task automatic send(input int net, input logic last);
        chk("in_ready_on_send", int'(in_ready), 1);
        in_valid = 1'b1;
        in_net   = NET_W'(net);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
        @(posedge clk); #1;
        chk({name, "_done_low"}, int'(done), 0);
        chk({name, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_valid_seen"}, int'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_net",   int'(out_net), 0);
        chk("rst_out_cnt",   int'(out_cnt), 0);
        chk("rst_done",      int'(done), 0);
        chk("rst_overflow",  int'(overflow), 0);

        // Basic count
        thr = 4'd2;
        push_exp(3, 3);
        send(3, 1'b0);
        send(3, 1'b0);
        send(5, 1'b0);
        send(3, 1'b1);
        wait_done("basic");

        // Backpressure
        out_ready = 1'b0;
        thr = 4'd2;
        push_exp(1, 2);
        push_exp(2, 2);
        send(1, 1'b0);
        send(1, 1'b0);
        send(2, 1'b0);
        send(2, 1'b1);
        wait_valid("bp");
        chk("bp_first_net", int'(out_net), 1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("bp_no_done_while_stalled", int'(done), 0);
        out_ready = 1'b1;
        wait_done("bp");

        // Saturation / wrap
        thr = 4'd1;
`ifdef FANOUT_ACC_SAT_EN
        push_exp(6, 15);
`else
        push_exp(6, 1);
`endif
        for (int i = 0; i < 17; i++) begin
            send(6, (i == 16));
        end
        wait_done("sat");
        chk("sat_overflow", int'(overflow), 1);

        // Threshold zero, latency of first result and of done
        thr = 4'd0;
        push_exp(0, 1);
        send(0, 1'b1);
        chk("thr0_no_valid_at_T1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("thr0_valid_at_T2", int'(out_valid), 1);
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("thr0_done_latency", n, DEPTH + 1);
        chk("thr0_overflow_sticky", int'(overflow), 1);
        @(posedge clk); #1;
        chk("thr0_in_ready", int'(in_ready), 1);

        // Reset while a result is pending
        out_ready = 1'b0;
        thr = 4'd1;
        send(4, 1'b0);
        send(4, 1'b0);
        send(4, 1'b1);
        wait_valid("rstd");
        chk("rstd_pending_net", int'(out_net), 4);
        chk("rstd_pending_cnt", int'(out_cnt), 3);
        rst = 1'b1;
        #1;
        chk("rstd_out_valid", int'(out_valid), 0);
        chk("rstd_in_ready",  int'(in_ready), 1);
        chk("rstd_overflow",  int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_exp(4, 1);
        send(4, 1'b1);
        wait_done("rstd");

        // Consecutive netlists; input held valid during drain/clear
        thr = 4'd2;
        push_exp(7, 2);
        send(7, 1'b0);
        send(7, 1'b0);
        send(9, 1'b1);
        chk("cons_in_ready_drain", int'(in_ready), 0);
        in_valid = 1'b1;
        in_net   = 4'd7;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cons_done_seen", int'(done), 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("cons_in_ready_back", int'(in_ready), 1);
        thr = 4'd1;
        push_exp(7, 1);
        push_exp(9, 1);
        send(7, 1'b0);
        send(9, 1'b1);
        wait_done("cons2");

        repeat (2) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
